// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the external memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_D    = 2'd1,
        OWN_I    = 2'd2,
        OWN_P    = 2'd3
    } owner_t;

    // Bit positions inside the one-hot winner vector.
    localparam int WIN_D = 0;
    localparam int WIN_I = 1;
    localparam int WIN_P = 2;

    localparam int DEF_BLOCK_WORDS = 4;
    localparam int BEAT_W          = $clog2(DEF_BLOCK_WORDS);
    localparam int OFFS_W          = BEAT_W + 2;

    function automatic int offs_w_of(input int block_words);
        return $clog2(block_words) + 2;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Combinational requester selection: D > I > P, with the starve flag lifting P to the top.
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic       d_req,
    input  logic       i_req,
    input  logic       p_req,
    input  logic       starve,
    output logic [2:0] win
);

    always_comb begin
        win = '0;
        if (starve && p_req) begin
            win[WIN_P] = 1'b1;
        end else if (d_req) begin
            win[WIN_D] = 1'b1;
        end else if (i_req) begin
            win[WIN_I] = 1'b1;
        end else if (p_req) begin
            win[WIN_P] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises D-cache, I-cache refill and prefetch traffic onto one memory port.
// Optional prefetch anti-starvation guard: define MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int BLOCK_WORDS  = DEF_BLOCK_WORDS,
    parameter int STARVE_LIMIT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic              d_last_o,
    input  logic              i_req_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic              i_gnt_o,
    output logic              i_rvalid_o,
    output logic              i_last_o,
    input  logic              p_req_i,
    input  logic [ADDR_W-1:0] p_addr_i,
    output logic              p_gnt_o,
    output logic              p_rvalid_o,
    output logic              p_last_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o
);

    localparam int CNT_W = $clog2(BLOCK_WORDS);
    localparam int OFFS  = offs_w_of(BLOCK_WORDS);

    localparam logic [ADDR_W-1:0] RD_MASK = {{(ADDR_W-OFFS){1'b1}}, {OFFS{1'b0}}};
    localparam logic [ADDR_W-1:0] WR_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    arb_state_t        state, state_nxt;
    owner_t            owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CNT_W-1:0]  beat_q;

    logic [2:0]        win;
    logic              starve;
    logic              take;
    logic              beat;
    logic              last_beat;
    logic              win_we;
    logic [ADDR_W-1:0] sel_addr;

    mem_arb_pick u_pick (
        .d_req  (d_req_i),
        .i_req  (i_req_i),
        .p_req  (p_req_i),
        .starve (starve),
        .win    (win)
    );

    assign take      = (state == ST_IDLE) && (|win);
    assign beat      = (state == ST_XFER) && mem_rvalid_i;
    assign last_beat = beat && (we_q || (beat_q == CNT_W'(BLOCK_WORDS - 1)));
    assign win_we    = win[WIN_D] && d_we_i;
    assign sel_addr  = win[WIN_D] ? d_addr_i : (win[WIN_I] ? i_addr_i : p_addr_i);

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [STARVE_W-1:0] starve_q;

    always_ff @(posedge clk) begin
        if (reset || !p_req_i || p_gnt_o) begin
            starve_q <= '0;
        end else if (starve_q != STARVE_W'(STARVE_LIMIT)) begin
            starve_q <= starve_q + 1'b1;
        end
    end

    assign starve = (starve_q == STARVE_W'(STARVE_LIMIT));
`else
    assign starve = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (|win)     state_nxt = ST_REQ;
            ST_REQ:  if (mem_gnt_i) state_nxt = ST_XFER;
            ST_XFER: if (last_beat) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= OWN_NONE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (take) begin
            owner_q <= win[WIN_D] ? OWN_D : (win[WIN_I] ? OWN_I : OWN_P);
            we_q    <= win_we;
            addr_q  <= sel_addr & (win_we ? WR_MASK : RD_MASK);
            wdata_q <= win_we ? d_wdata_i : '0;
        end
    end

    // Write acks do not advance the counter, so it sits at 0 between bursts.
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_q <= '0;
        end else if (beat && !we_q) begin
            beat_q <= beat_q + 1'b1;
        end
    end

    always_comb begin
        d_gnt_o     = 1'b0;
        i_gnt_o     = 1'b0;
        p_gnt_o     = 1'b0;
        d_rvalid_o  = 1'b0;
        i_rvalid_o  = 1'b0;
        p_rvalid_o  = 1'b0;
        d_last_o    = 1'b0;
        i_last_o    = 1'b0;
        p_last_o    = 1'b0;
        rdata_o     = '0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        busy_o      = 1'b0;
        if (!reset) begin
            busy_o = (state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    d_gnt_o = win[WIN_D];
                    i_gnt_o = win[WIN_I];
                    p_gnt_o = win[WIN_P];
                end
                ST_REQ: begin
                    mem_req_o   = 1'b1;
                    mem_we_o    = we_q;
                    mem_addr_o  = addr_q;
                    mem_wdata_o = wdata_q;
                end
                ST_XFER: begin
                    if (mem_rvalid_i) begin
                        rdata_o = mem_rdata_i;
                        case (owner_q)
                            OWN_D: begin
                                d_rvalid_o = 1'b1;
                                d_last_o   = last_beat;
                            end
                            OWN_I: begin
                                i_rvalid_o = 1'b1;
                                i_last_o   = last_beat;
                            end
                            OWN_P: begin
                                p_rvalid_o = 1'b1;
                                p_last_o   = last_beat;
                            end
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: arbitration table, directed corner sequences, random traffic vs. a transaction model.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BW     = 4;
    localparam int LIMIT  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              d_req_i, d_we_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [DATA_W-1:0] d_wdata_i;
    logic              d_gnt_o, d_rvalid_o, d_last_o;
    logic              i_req_i;
    logic [ADDR_W-1:0] i_addr_i;
    logic              i_gnt_o, i_rvalid_o, i_last_o;
    logic              p_req_i;
    logic [ADDR_W-1:0] p_addr_i;
    logic              p_gnt_o, p_rvalid_o, p_last_o;
    logic [DATA_W-1:0] rdata_o;
    logic              mem_req_o, mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_gnt_i, mem_rvalid_i;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              busy_o;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BLOCK_WORDS(BW), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .reset(reset),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_last_o(d_last_o),
        .i_req_i(i_req_i), .i_addr_i(i_addr_i),
        .i_gnt_o(i_gnt_o), .i_rvalid_o(i_rvalid_o), .i_last_o(i_last_o),
        .p_req_i(p_req_i), .p_addr_i(p_addr_i),
        .p_gnt_o(p_gnt_o), .p_rvalid_o(p_rvalid_o), .p_last_o(p_last_o),
        .rdata_o(rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        d, i, p, we;
        logic [31:0] addr;
        logic [2:0]  exp_g;
        logic [31:0] exp_addr;
        logic        exp_we;
    } vec_t;

    vec_t        vecs [7];
    logic        bv [5];
    logic [31:0] bd [5];
    logic        bl [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Packed view: {gnt[P,I,D], rvalid[P,I,D], last[P,I,D], mem_req, busy}
    function automatic logic [10:0] ctrl_now();
        return {p_gnt_o, i_gnt_o, d_gnt_o, p_rvalid_o, i_rvalid_o, d_rvalid_o,
                p_last_o, i_last_o, d_last_o, mem_req_o, busy_o};
    endfunction

    function automatic logic [10:0] mk(input logic [2:0] g, input logic [2:0] rv,
                                       input logic [2:0] l, input logic mreq, input logic busy);
        return {g, rv, l, mreq, busy};
    endfunction

    task automatic clear_inputs();
        d_req_i = 0; d_we_i = 0; d_addr_i = '0; d_wdata_i = '0;
        i_req_i = 0; i_addr_i = '0; p_req_i = 0; p_addr_i = '0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Transaction-level reference state for the random run.
    logic        m_busy, m_acc, m_we;
    int          m_owner, m_beats;
    logic [31:0] m_addr, m_wdata;
`ifdef MEM_ARB_STARVE_GUARD_EN
    int          m_starve;
`endif

    initial begin
        logic [2:0]  eg, erv, el;
        logic        emreq, starve_hit;
        int          first_pg, pg_count;

        reset = 1'b1;
        clear_inputs();

        vecs[0] = '{1, 0, 0, 0, 32'h0000_1234, 3'b001, 32'h0000_1230, 0};
        vecs[1] = '{1, 0, 0, 1, 32'h0000_0107, 3'b001, 32'h0000_0104, 1};
        vecs[2] = '{0, 1, 0, 0, 32'h0000_1234, 3'b010, 32'h0000_1230, 0};
        vecs[3] = '{0, 0, 1, 0, 32'hFFFF_FFFF, 3'b100, 32'hFFFF_FFF0, 0};
        vecs[4] = '{1, 1, 1, 1, 32'hABCD_EF03, 3'b001, 32'hABCD_EF00, 1};
        vecs[5] = '{0, 1, 1, 0, 32'h0000_001C, 3'b010, 32'h0000_0010, 0};
        vecs[6] = '{0, 0, 0, 0, 32'h0000_0040, 3'b000, 32'h0000_0000, 0};

        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("reset_ctrl", 64'(ctrl_now()), 0);
        chk("reset_addr", 64'(mem_addr_o), 0);

        // Arbitration and alignment table
        for (int k = 0; k < 7; k++) begin
            do_reset();
            d_req_i = vecs[k].d; i_req_i = vecs[k].i; p_req_i = vecs[k].p;
            d_we_i = vecs[k].we; d_wdata_i = 32'h1111_0000 + 32'(k);
            d_addr_i = vecs[k].addr; i_addr_i = vecs[k].addr; p_addr_i = vecs[k].addr;
            #1 chk("vec_gnt", 64'(ctrl_now()), 64'(mk(vecs[k].exp_g, 0, 0, 0, 0)));
            @(negedge clk);
            clear_inputs();
            #1;
            if (vecs[k].exp_g != 3'b000) begin
                chk("vec_req_ctrl", 64'(ctrl_now()), 64'(mk(0, 0, 0, 1, 1)));
                chk("vec_addr", 64'(mem_addr_o), 64'(vecs[k].exp_addr));
                chk("vec_we", 64'(mem_we_o), 64'(vecs[k].exp_we));
                if (vecs[k].exp_we) chk("vec_wdata", 64'(mem_wdata_o), 64'(32'h1111_0000 + 32'(k)));
            end else begin
                chk("vec_idle_ctrl", 64'(ctrl_now()), 0);
            end
        end

        // I-side burst with a stalled address phase and a stray beat
        do_reset();
        i_req_i = 1; i_addr_i = 32'h0000_1234;
        #1 chk("a_igrant", 64'(ctrl_now()), 64'(mk(3'b010, 0, 0, 0, 0)));
        @(negedge clk);
        i_req_i = 0; d_req_i = 1; p_req_i = 1;
        for (int k = 0; k < 5; k++) begin
            mem_rvalid_i = (k == 0); mem_rdata_i = 32'hBAD0;
            #1 chk("a_stall_ctrl", 64'(ctrl_now()), 64'(mk(0, 0, 0, 1, 1)));
            chk("a_stall_addr", 64'(mem_addr_o), 64'h1230);
            @(negedge clk);
        end
        d_req_i = 0; p_req_i = 0; mem_rvalid_i = 0; mem_gnt_i = 1;
        #1 chk("a_gnt_ctrl", 64'(ctrl_now()), 64'(mk(0, 0, 0, 1, 1)));
        @(negedge clk);
        mem_gnt_i = 0;
        bv = '{1, 0, 1, 1, 1};
        bd = '{32'hA0, 32'h0, 32'hA1, 32'hA2, 32'hA3};
        bl = '{0, 0, 0, 0, 1};
        for (int k = 0; k < 5; k++) begin
            mem_rvalid_i = bv[k]; mem_rdata_i = bd[k];
            #1 chk("a_beat_ctrl", 64'(ctrl_now()),
                   64'(mk(0, {1'b0, bv[k], 1'b0}, {1'b0, bl[k], 1'b0}, 0, 1)));
            if (bv[k]) chk("a_beat_data", 64'(rdata_o), 64'(bd[k]));
            @(negedge clk);
        end
        mem_rvalid_i = 0;
        #1 chk("a_idle_after", 64'(ctrl_now()), 0);

        // Same-cycle D write vs I read
        do_reset();
        d_req_i = 1; d_we_i = 1; d_addr_i = 32'h100; d_wdata_i = 32'hDEAD;
        i_req_i = 1; i_addr_i = 32'h2000;
        #1 chk("b_dgrant", 64'(ctrl_now()), 64'(mk(3'b001, 0, 0, 0, 0)));
        @(negedge clk);
        d_req_i = 0; mem_gnt_i = 1;
        #1 chk("b_req_ctrl", 64'(ctrl_now()), 64'(mk(0, 0, 0, 1, 1)));
        chk("b_we", 64'(mem_we_o), 1);
        chk("b_wdata", 64'(mem_wdata_o), 64'hDEAD);
        chk("b_addr", 64'(mem_addr_o), 64'h100);
        @(negedge clk);
        mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h0;
        #1 chk("b_ack", 64'(ctrl_now()), 64'(mk(0, 3'b001, 3'b001, 0, 1)));
        @(negedge clk);
        mem_rvalid_i = 0;
        #1 chk("b_igrant", 64'(ctrl_now()), 64'(mk(3'b010, 0, 0, 0, 0)));
        @(negedge clk);
        i_req_i = 0;
        #1 chk("b_iaddr", 64'(mem_addr_o), 64'h2000);

        // Reset in the middle of a P burst
        do_reset();
        p_req_i = 1; p_addr_i = 32'h44;
        #1 chk("c_pgrant", 64'(ctrl_now()), 64'(mk(3'b100, 0, 0, 0, 0)));
        @(negedge clk);
        p_req_i = 0; mem_gnt_i = 1;
        @(negedge clk);
        mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hC0;
        #1 chk("c_beat0", 64'(ctrl_now()), 64'(mk(0, 3'b100, 0, 0, 1)));
        @(negedge clk);
        mem_rdata_i = 32'hC1;
        #1 chk("c_beat1", 64'(ctrl_now()), 64'(mk(0, 3'b100, 0, 0, 1)));
        @(negedge clk);
        mem_rvalid_i = 0; reset = 1;
        @(negedge clk);
        reset = 0;
        #1 chk("c_post_ctrl", 64'(ctrl_now()), 0);
        chk("c_post_addr", 64'(mem_addr_o), 0);
        chk("c_post_we", 64'(mem_we_o), 0);
        chk("c_post_wdata", 64'(mem_wdata_o), 0);
        chk("c_post_rdata", 64'(rdata_o), 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            mem_rvalid_i = 1; mem_rdata_i = 32'hC2 + 32'(k);
            #1 chk("c_stray", 64'(ctrl_now()), 0);
        end

        // Prefetch under continuous D/I pressure
        do_reset();
        d_req_i = 1; d_we_i = 1; d_addr_i = 32'h200; i_req_i = 1; i_addr_i = 32'h300;
        p_req_i = 1; p_addr_i = 32'h400; mem_gnt_i = 1; mem_rvalid_i = 1;
        first_pg = -1; pg_count = 0;
        for (int c = 0; c < 120; c++) begin
            #1;
            if (p_gnt_o) begin
                if (first_pg < 0) first_pg = c;
                pg_count++;
            end
            @(negedge clk);
        end
`ifdef MEM_ARB_STARVE_GUARD_EN
        // D writes take 3 cycles, so IDLE lands on multiples of 3.
        chk("starve_first_pgnt", 64'(first_pg), 64'(((LIMIT + 2) / 3) * 3));
`else
        chk("starve_off_pgnt", 64'(pg_count), 0);
`endif

        // Random traffic against the transaction model
        do_reset();
        m_busy = 0; m_acc = 0; m_we = 0; m_owner = 0; m_beats = 0; m_addr = '0; m_wdata = '0;
`ifdef MEM_ARB_STARVE_GUARD_EN
        m_starve = 0;
`endif
        for (int c = 0; c < 3000; c++) begin
            d_req_i = ($urandom_range(0, 99) < 35); d_we_i = $urandom_range(0, 1) == 1;
            d_addr_i = $urandom; d_wdata_i = $urandom;
            i_req_i = ($urandom_range(0, 99) < 35); i_addr_i = $urandom;
            p_req_i = ($urandom_range(0, 99) < 40); p_addr_i = $urandom;
            mem_gnt_i = ($urandom_range(0, 99) < 40);
            mem_rvalid_i = ($urandom_range(0, 99) < 50); mem_rdata_i = $urandom;
            #1;
            eg = 0; erv = 0; el = 0; emreq = 0; starve_hit = 0;
            if (!m_busy) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
                starve_hit = (m_starve >= LIMIT) && p_req_i;
`endif
                if (starve_hit)   eg = 3'b100;
                else if (d_req_i) eg = 3'b001;
                else if (i_req_i) eg = 3'b010;
                else if (p_req_i) eg = 3'b100;
            end else if (!m_acc) begin
                emreq = 1;
            end else if (mem_rvalid_i) begin
                erv[m_owner] = 1'b1;
                el[m_owner]  = m_we || (m_beats == BW - 1);
            end
            chk("rnd_ctrl", 64'(ctrl_now()), 64'(mk(eg, erv, el, emreq, m_busy)));
            if (emreq) begin
                chk("rnd_addr", 64'(mem_addr_o), 64'(m_addr));
                chk("rnd_we", 64'(mem_we_o), 64'(m_we));
                if (m_we) chk("rnd_wdata", 64'(mem_wdata_o), 64'(m_wdata));
            end
            if (erv != 3'b000) chk("rnd_rdata", 64'(rdata_o), 64'(mem_rdata_i));

            if (!m_busy && eg != 3'b000) begin
                m_busy  = 1; m_acc = 0; m_beats = 0;
                m_owner = eg[0] ? 0 : (eg[1] ? 1 : 2);
                m_we    = eg[0] && d_we_i;
                m_addr  = eg[0] ? d_addr_i : (eg[1] ? i_addr_i : p_addr_i);
                m_addr  = m_we ? (m_addr & ~32'h3) : (m_addr & ~32'(BW * 4 - 1));
                m_wdata = d_wdata_i;
            end else if (m_busy && !m_acc) begin
                if (mem_gnt_i) m_acc = 1;
            end else if (m_busy && mem_rvalid_i) begin
                if (m_we || m_beats == BW - 1) m_busy = 0;
                else m_beats++;
            end
`ifdef MEM_ARB_STARVE_GUARD_EN
            if (!p_req_i || eg[2]) m_starve = 0;
            else if (m_starve < LIMIT) m_starve++;
`endif
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
